// File: rtl/rnn_cell_param.sv
// Elman RNN cell engine: streams weights from a shared single-port memory,
// accumulates bias + binary-input + recurrent terms, and writes every h_t back.
module rnn_cell_param #(
    parameter int HID      = 64,
    parameter int IN_BITS  = 32,
    parameter int DW       = 20,
    parameter int FRAC     = 16,
    parameter int ACC_W    = 43,
    parameter int MUL_LAT  = 4,
    parameter int ACT_MODE = 0,
    parameter int T_W      = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic               done,
    output logic               i_en,
    input  logic [IN_BITS-1:0] idata,
    output logic               mce,
    output logic [2:0]         msel,
    output logic [16:0]        maddr,
    input  logic [DW-1:0]      mdata_r,
    output logic [DW-1:0]      mdata_w
);
    localparam int NW = $clog2(HID);
    localparam int JW = $clog2(IN_BITS);
    localparam int AW = 17;
    localparam int RW = ACC_W - FRAC;

    localparam logic [2:0] SEL_WX   = 3'b000;
    localparam logic [2:0] SEL_BIAS = 3'b001;
    localparam logic [2:0] SEL_WH   = 3'b010;
    localparam logic [2:0] SEL_HDR  = 3'b011;
    localparam logic [2:0] SEL_IDLE = 3'b100;
    localparam logic [2:0] SEL_WR   = 3'b101;

    localparam logic signed [RW-1:0] ONE_R = RW'(2 ** FRAC);
    localparam logic signed [RW-1:0] NEG_R = RW'(-(2 ** FRAC));
    localparam logic [DW-1:0]        ONE_D = DW'(2 ** FRAC);
    localparam logic [DW-1:0]        NEG_D = DW'(-(2 ** FRAC));

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_XIN, S_BIAS, S_WX, S_WH, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t               state_reg;
    logic [T_W-1:0]       t_cnt_reg, t_total_reg;
    logic [NW-1:0]        n_cnt_reg, k_cnt_reg, k_d_reg;
    logic [JW-1:0]        j_cnt_reg;
    logic [2:0]           d_cnt_reg;
    logic [IN_BITS-1:0]   x_reg;

    logic                 bias_v_reg, wx_v_reg, wx_bit_reg, wh_v_reg;
    logic signed [2*DW-1:0] prod_reg [MUL_LAT];
    logic [MUL_LAT-1:0]   prod_v_reg;
    logic signed [ACC_W-1:0] acc_reg, bias_term, wx_term, mul_term;
    logic signed [2*DW-1:0]  mul_a, mul_b;
    logic signed [RW-1:0] r_val;
    logic [DW-1:0]        act_val;
    logic signed [DW-1:0] h_prev_reg [HID];
    logic signed [DW-1:0] h_next_reg [HID];
    logic                 unused_low_bits;

    assign mce     = busy;
    assign mdata_w = (state_reg == S_WRITE) ? act_val : '0;

    // Control FSM; memory-side outputs are registered for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            i_en        <= 1'b0;
            msel        <= SEL_IDLE;
            maddr       <= '0;
            t_cnt_reg   <= '0;
            t_total_reg <= '0;
            n_cnt_reg   <= '0;
            j_cnt_reg   <= '0;
            k_cnt_reg   <= '0;
            d_cnt_reg   <= '0;
            x_reg       <= '0;
        end else begin
            done <= 1'b0;
            i_en <= 1'b0;
            case (state_reg)
                S_IDLE: if (ready) begin
                    state_reg <= S_HDR0;
                    busy      <= 1'b1;
                    msel      <= SEL_HDR;
                    maddr     <= '0;
                end
                S_HDR0: begin
                    state_reg <= S_HDR1;
                    msel      <= SEL_IDLE;
                end
                S_HDR1: begin
                    t_total_reg <= mdata_r[T_W-1:0];
                    t_cnt_reg   <= '0;
                    n_cnt_reg   <= '0;
                    if (mdata_r[T_W-1:0] == '0) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= S_XIN;
                        i_en      <= 1'b1;
                    end
                end
                S_XIN: begin
                    x_reg     <= idata;
                    state_reg <= S_BIAS;
                    msel      <= SEL_BIAS;
                    maddr     <= AW'(n_cnt_reg);
                end
                S_BIAS: begin
                    state_reg <= S_WX;
                    msel      <= SEL_WX;
                    j_cnt_reg <= '0;
                    maddr     <= AW'({n_cnt_reg, {JW{1'b0}}});
                end
                S_WX: if (j_cnt_reg == JW'(IN_BITS - 1)) begin
                    state_reg <= S_WH;
                    msel      <= SEL_WH;
                    k_cnt_reg <= '0;
                    maddr     <= AW'({n_cnt_reg, {NW{1'b0}}});
                end else begin
                    j_cnt_reg <= j_cnt_reg + 1'b1;
                    maddr     <= AW'({n_cnt_reg, JW'(j_cnt_reg + 1'b1)});
                end
                S_WH: if (k_cnt_reg == NW'(HID - 1)) begin
                    state_reg <= S_DRAIN;
                    msel      <= SEL_IDLE;
                    maddr     <= '0;
                    d_cnt_reg <= '0;
                end else begin
                    k_cnt_reg <= k_cnt_reg + 1'b1;
                    maddr     <= AW'({n_cnt_reg, NW'(k_cnt_reg + 1'b1)});
                end
                // Drain lets the last recurrent product land before the write.
                S_DRAIN: if (d_cnt_reg == 3'(MUL_LAT)) begin
                    state_reg <= S_WRITE;
                    msel      <= SEL_WR;
                    maddr     <= AW'({t_cnt_reg, n_cnt_reg});
                end else begin
                    d_cnt_reg <= d_cnt_reg + 1'b1;
                end
                S_WRITE: begin
                    msel  <= SEL_IDLE;
                    maddr <= '0;
                    if (n_cnt_reg == NW'(HID - 1)) begin
                        n_cnt_reg <= '0;
                        t_cnt_reg <= t_cnt_reg + 1'b1;
                        if (T_W'(t_cnt_reg + 1'b1) == t_total_reg) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= S_XIN;
                            i_en      <= 1'b1;
                        end
                    end else begin
                        n_cnt_reg <= n_cnt_reg + 1'b1;
                        state_reg <= S_BIAS;
                        msel      <= SEL_BIAS;
                        maddr     <= AW'(NW'(n_cnt_reg + 1'b1));
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after issue, so the qualifiers are delayed to match.
    assign mul_a = (2*DW)'(h_prev_reg[k_d_reg]);
    assign mul_b = (2*DW)'(signed'(mdata_r));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_v_reg <= 1'b0;
            wx_v_reg   <= 1'b0;
            wx_bit_reg <= 1'b0;
            wh_v_reg   <= 1'b0;
            k_d_reg    <= '0;
            prod_v_reg <= '0;
            for (int i = 0; i < MUL_LAT; i++) prod_reg[i] <= '0;
        end else begin
            bias_v_reg <= (state_reg == S_BIAS);
            wx_v_reg   <= (state_reg == S_WX);
            wx_bit_reg <= x_reg[j_cnt_reg];
            wh_v_reg   <= (state_reg == S_WH);
            k_d_reg    <= k_cnt_reg;
            prod_reg[0]   <= mul_a * mul_b;
            prod_v_reg[0] <= wh_v_reg;
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_reg[i]   <= prod_reg[i-1];
                prod_v_reg[i] <= prod_v_reg[i-1];
            end
        end
    end

    always_comb begin
        bias_term = '0;
        wx_term   = '0;
        mul_term  = '0;
        if (bias_v_reg)
            bias_term = {{(ACC_W-DW-FRAC){mdata_r[DW-1]}}, mdata_r, {FRAC{1'b0}}};
        if (wx_v_reg && wx_bit_reg)
            wx_term = {{(ACC_W-DW-FRAC){mdata_r[DW-1]}}, mdata_r, {FRAC{1'b0}}};
        if (prod_v_reg[MUL_LAT-1])
            mul_term = ACC_W'(prod_reg[MUL_LAT-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_reg <= '0;
        else if (state_reg == S_WRITE)
            acc_reg <= '0;
        else
            acc_reg <= acc_reg + bias_term + wx_term + mul_term;
    end

    assign r_val           = acc_reg[ACC_W-1:FRAC] + {{(RW-1){1'b0}}, acc_reg[FRAC-1]};
    assign unused_low_bits = &{1'b0, acc_reg[FRAC-2:0]};

    always_comb begin
        act_val = r_val[DW-1:0];
        if (ACT_MODE == 0) begin
            if (r_val > ONE_R)      act_val = ONE_D;
            else if (r_val < NEG_R) act_val = NEG_D;
        end else begin
            if (r_val < 0)          act_val = '0;
            else if (r_val > ONE_R) act_val = ONE_D;
        end
    end

    // h_next collects the current step; the last write also commits it to h_prev.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HID; i++) begin
                h_prev_reg[i] <= '0;
                h_next_reg[i] <= '0;
            end
        end else if (state_reg == S_HDR0) begin
            for (int i = 0; i < HID; i++) h_prev_reg[i] <= '0;
        end else if (state_reg == S_WRITE) begin
            h_next_reg[n_cnt_reg] <= act_val;
            if (n_cnt_reg == NW'(HID - 1)) begin
                for (int i = 0; i < HID; i++)
                    h_prev_reg[i] <= (NW'(i) == n_cnt_reg) ? act_val : h_next_reg[i];
            end
        end
    end
endmodule
